// File: rtl/nrisc_int_ctrl.sv
// ----------------------------------------------------------------------------
// nrisc_int_ctrl
//
// Interrupt controller feeding the NRISC core's INTERRUPT_flag / INTERRUPT_ch
// inputs. Raw IRQ lines are double-synchronised, edge events are latched per
// source, masked, and the lowest-index eligible source is presented to the
// core. The core handshakes with a one-cycle INT_ack when it vectors and a
// one-cycle INT_eoi when the handler returns. No nesting: while a request is
// in service no new flag is raised, although pending bits keep accumulating.
//
// Ports:
//   clk            main clock, all state on posedge
//   rst            asynchronous active-low reset
//   IRQ_in         raw interrupt lines (asynchronous to clk)
//   INT_CFG_addr   register select: 0 MASK, 1 MODE, 2 PENDING, 3 STATUS
//   INT_CFG_wdata  register write data
//   INT_CFG_write  register write strobe (one cycle per write)
//   INT_CFG_rdata  register read data, combinational from INT_CFG_addr
//   INT_ack        core has vectored to INTERRUPT_ch (one-cycle pulse)
//   INT_eoi        core returned from handler (one-cycle pulse)
//   INTERRUPT_ch   channel of the presented request (zero-extended index)
//   INTERRUPT_flag request to core (registered)
// ----------------------------------------------------------------------------
module nrisc_int_ctrl #(
    parameter int unsigned TAM   = 16,
    parameter int unsigned N_SRC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] IRQ_in,
    input  logic [1:0]       INT_CFG_addr,
    input  logic [TAM-1:0]   INT_CFG_wdata,
    input  logic             INT_CFG_write,
    output logic [TAM-1:0]   INT_CFG_rdata,
    input  logic             INT_ack,
    input  logic             INT_eoi,
    output logic [7:0]       INTERRUPT_ch,
    output logic             INTERRUPT_flag
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StService
    } state_e;

    localparam logic [1:0] AddrMask    = 2'd0;
    localparam logic [1:0] AddrMode    = 2'd1;
    localparam logic [1:0] AddrPending = 2'd2;
    localparam logic [1:0] AddrStatus  = 2'd3;

    // Synchroniser chain; r_s3 is the history flop used only for edge detection.
    logic [N_SRC-1:0] r_s1;
    logic [N_SRC-1:0] r_s2;
    logic [N_SRC-1:0] r_s3;

    logic [N_SRC-1:0] r_pending;
    logic [N_SRC-1:0] r_mask;
    logic [N_SRC-1:0] r_mode;

    state_e           r_state;
    logic [7:0]       r_ch;
    logic             r_flag;

    logic [N_SRC-1:0] w_edge;
    logic [N_SRC-1:0] w_elig;
    logic             w_any;
    logic [7:0]       w_win;
    logic [N_SRC-1:0] w_ch_sel;
    logic             w_ch_elig;
    logic             w_ack_take;
    logic [N_SRC-1:0] w_w1c;
    logic [N_SRC-1:0] w_clr;
    logic [N_SRC-1:0] w_pending_d;
    logic             w_wr_mask;
    logic             w_wr_mode;
    logic             w_wr_pending;

    assign w_edge = r_s2 & ~r_s3;
    assign w_elig = r_pending & r_mask;
    assign w_any  = |w_elig;

    // Lowest index wins: scan from the top so the last hit is the lowest bit.
    always_comb begin
        w_win = 8'd0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_win = 8'(i);
            end
        end
    end

    // One-hot decode of the frozen channel, used for withdrawal and ack-clear.
    always_comb begin
        w_ch_sel = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            w_ch_sel[i] = (r_ch == 8'(i));
        end
    end

    assign w_ch_elig  = |(w_elig & w_ch_sel);
    assign w_ack_take = (r_state == StReq) && INT_ack;

    assign w_wr_mask    = INT_CFG_write && (INT_CFG_addr == AddrMask);
    assign w_wr_mode    = INT_CFG_write && (INT_CFG_addr == AddrMode);
    assign w_wr_pending = INT_CFG_write && (INT_CFG_addr == AddrPending);

    // W1C only touches edge-mode bits; level bits are rebuilt from s2 anyway.
    assign w_w1c = w_wr_pending ? (INT_CFG_wdata[N_SRC-1:0] & r_mode) : '0;
    assign w_clr = w_w1c | (w_ack_take ? (w_ch_sel & r_mode) : '0);

    // Edge bits: clear first, then OR in the new edge so a coincident event
    // survives the clear. Level bits simply track the synchronised line.
    assign w_pending_d = (r_mode & ((r_pending & ~w_clr) | w_edge)) | (~r_mode & r_s2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_s3      <= '0;
            r_pending <= '0;
            r_mask    <= '0;
            r_mode    <= '0;
        end else begin
            r_s1      <= IRQ_in;
            r_s2      <= r_s1;
            r_s3      <= r_s2;
            r_pending <= w_pending_d;
            if (w_wr_mask) begin
                r_mask <= INT_CFG_wdata[N_SRC-1:0];
            end
            if (w_wr_mode) begin
                r_mode <= INT_CFG_wdata[N_SRC-1:0];
            end
        end
    end

    // Request sequencer with registered flag and channel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
            r_ch    <= 8'd0;
            r_flag  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_any) begin
                        r_state <= StReq;
                        r_ch    <= w_win;
                        r_flag  <= 1'b1;
                    end
                end
                StReq: begin
                    // Ack takes precedence over a same-cycle withdrawal.
                    if (INT_ack) begin
                        r_state <= StService;
                        r_flag  <= 1'b0;
                    end else if (!w_ch_elig) begin
                        r_state <= StIdle;
                        r_flag  <= 1'b0;
                    end
                end
                StService: begin
                    if (INT_eoi) begin
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_flag  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        INT_CFG_rdata = '0;
        unique case (INT_CFG_addr)
            AddrMask:    INT_CFG_rdata[N_SRC-1:0] = r_mask;
            AddrMode:    INT_CFG_rdata[N_SRC-1:0] = r_mode;
            AddrPending: INT_CFG_rdata[N_SRC-1:0] = r_pending;
            AddrStatus:  INT_CFG_rdata[9:0]       = {(r_state == StService), r_flag, r_ch};
            default:     INT_CFG_rdata            = '0;
        endcase
    end

    assign INTERRUPT_ch   = r_ch;
    assign INTERRUPT_flag = r_flag;

    // Write data above the source count has no destination.
    if (TAM > N_SRC) begin : g_wdata_unused
        logic w_unused_wdata;
        assign w_unused_wdata = ^INT_CFG_wdata[TAM-1:N_SRC];
    end

endmodule

// File: tb/tb_nrisc_int_ctrl.sv
module tb_nrisc_int_ctrl;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic [7:0]  irq   = 8'h00;
    logic [1:0]  addr  = 2'd0;
    logic [15:0] wdata = 16'h0000;
    logic        wr    = 1'b0;
    logic        ack   = 1'b0;
    logic        eoi   = 1'b0;
    logic [15:0] rdata;
    logic [7:0]  ch;
    logic        flag;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    nrisc_int_ctrl #(
        .TAM   (16),
        .N_SRC (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .IRQ_in         (irq),
        .INT_CFG_addr   (addr),
        .INT_CFG_wdata  (wdata),
        .INT_CFG_write  (wr),
        .INT_CFG_rdata  (rdata),
        .INT_ack        (ack),
        .INT_eoi        (eoi),
        .INTERRUPT_ch   (ch),
        .INTERRUPT_flag (flag)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Line history: m_hist[0] newest sample of IRQ_in, m_hist[1] the one
    // before, m_hist[2] the one before that. An event is a 0->1 step between
    // the two older samples.
    bit [7:0] m_hist [3];
    bit [7:0] m_pend, m_mask, m_mode;
    int       m_st;     // 0 idle, 1 requesting, 2 in service
    bit [7:0] m_ch;
    bit       m_flag;

    bit [7:0] t_ev, t_elig, t_clr, t_np;
    int       t_win;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) m_hist[i] = 8'h00;
            m_pend = 0; m_mask = 0; m_mode = 0;
            m_st = 0; m_ch = 0; m_flag = 0;
        end else begin
            t_ev   = m_hist[1] & ~m_hist[2];
            t_elig = m_pend & m_mask;
            t_win  = -1;
            for (int i = 0; i < 8; i++) if (t_elig[i] && t_win < 0) t_win = i;
            t_clr = 8'h00;
            if (wr && addr == 2'd2) t_clr = wdata[7:0] & m_mode;
            if (m_st == 0) begin
                if (t_win >= 0) begin
                    m_st = 1; m_ch = 8'(t_win); m_flag = 1;
                end
            end else if (m_st == 1) begin
                if (ack) begin
                    m_st = 2; m_flag = 0;
                    if (m_mode[m_ch[2:0]]) t_clr[m_ch[2:0]] = 1'b1;
                end else if (!t_elig[m_ch[2:0]]) begin
                    m_st = 0; m_flag = 0;
                end
            end else begin
                if (eoi) m_st = 0;
            end
            for (int i = 0; i < 8; i++) begin
                if (m_mode[i]) t_np[i] = (m_pend[i] && !t_clr[i]) || t_ev[i];
                else           t_np[i] = m_hist[1][i];
            end
            m_pend = t_np;
            if (wr && addr == 2'd0) m_mask = wdata[7:0];
            if (wr && addr == 2'd1) m_mode = wdata[7:0];
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = irq;
        end
    end

    function automatic logic [15:0] exp_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {8'h00, m_mask};
            2'd1:    return {8'h00, m_mode};
            2'd2:    return {8'h00, m_pend};
            default: return {6'b0, (m_st == 2), m_flag, m_ch};
        endcase
    endfunction

    always @(negedge clk) begin
        chk("model_flag", {15'b0, flag}, {15'b0, m_flag});
        if (m_flag) chk("model_ch", {8'h00, ch}, {8'h00, m_ch});
        chk("model_rdata", rdata, exp_rd(addr));
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wreg(input logic [1:0] a, input logic [15:0] d);
        addr = a; wdata = d; wr = 1'b1;
        cyc(1);
        wr = 1'b0;
    endtask

    task automatic rd(input string n, input logic [1:0] a, input logic [15:0] e);
        addr = a;
        #1;
        chk(n, rdata, e);
    endtask

    task automatic pulse(input logic [7:0] v);
        irq = v;
        cyc(1);
        irq = 8'h00;
    endtask

    task automatic do_ack();
        ack = 1'b1; cyc(1); ack = 1'b0;
    endtask

    task automatic do_eoi();
        eoi = 1'b1; cyc(1); eoi = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        chk("reset_flag", {15'b0, flag}, 16'h0);
        chk("reset_ch", {8'h00, ch}, 16'h0);
        rd("reset_mask", 2'd0, 16'h0000);
        rd("reset_pending", 2'd2, 16'h0000);

        // Single edge on source 5: flag three edges after first sample.
        wreg(2'd0, 16'h00FF);
        wreg(2'd1, 16'h00FF);
        pulse(8'h20);
        cyc(2);
        chk("t1_flag_early", {15'b0, flag}, 16'h0);
        cyc(1);
        chk("t1_flag", {15'b0, flag}, 16'h1);
        chk("t1_ch", {8'h00, ch}, 16'h5);
        do_ack();
        chk("t1_flag_after_ack", {15'b0, flag}, 16'h0);
        rd("t1_pending", 2'd2, 16'h0000);
        rd("t1_status_svc", 2'd3, 16'h0205);
        do_eoi();
        rd("t1_status_idle", 2'd3, 16'h0005);
        chk("t1_flag_after_eoi", {15'b0, flag}, 16'h0);

        // Two sources together: lowest index first, the other after EOI.
        pulse(8'h44);
        cyc(3);
        chk("t2_ch2", {8'h00, ch}, 16'h2);
        do_ack();
        rd("t2_pending", 2'd2, 16'h0040);
        do_eoi();
        chk("t2_flag_idle", {15'b0, flag}, 16'h0);
        cyc(1);
        chk("t2_flag6", {15'b0, flag}, 16'h1);
        chk("t2_ch6", {8'h00, ch}, 16'h6);
        do_ack();
        rd("t2_pending_clear", 2'd2, 16'h0000);
        do_eoi();

        // No preemption of a frozen channel.
        pulse(8'h10);
        cyc(3);
        chk("t3_ch4", {8'h00, ch}, 16'h4);
        pulse(8'h02);
        cyc(3);
        chk("t3_still4", {8'h00, ch}, 16'h4);
        do_ack();
        do_eoi();
        cyc(1);
        chk("t3_flag1", {15'b0, flag}, 16'h1);
        chk("t3_ch1", {8'h00, ch}, 16'h1);
        do_ack();
        do_eoi();

        // Masking the frozen channel withdraws; unmasking re-presents.
        pulse(8'h08);
        cyc(3);
        chk("t4_ch3", {8'h00, ch}, 16'h3);
        wreg(2'd0, 16'h00F7);
        cyc(1);
        chk("t4_withdrawn", {15'b0, flag}, 16'h0);
        rd("t4_status", 2'd3, 16'h0003);
        wreg(2'd0, 16'h00FF);
        cyc(1);
        chk("t4_reflag", {15'b0, flag}, 16'h1);
        chk("t4_rech3", {8'h00, ch}, 16'h3);
        do_ack();
        do_eoi();

        // Edge latching and W1C with everything masked.
        wreg(2'd0, 16'h0000);
        pulse(8'h0A);
        cyc(2);
        rd("w1c_latched", 2'd2, 16'h000A);
        wreg(2'd2, 16'h0002);
        rd("w1c_one", 2'd2, 16'h0008);
        wreg(2'd2, 16'h0008);
        rd("w1c_all", 2'd2, 16'h0000);

        // Level mode on source 0.
        wreg(2'd1, 16'h0000);
        wreg(2'd0, 16'h0001);
        irq = 8'h01;
        cyc(4);
        chk("t5_flag", {15'b0, flag}, 16'h1);
        chk("t5_ch0", {8'h00, ch}, 16'h0);
        wreg(2'd2, 16'h0001);
        rd("t5_w1c_ignored", 2'd2, 16'h0001);
        do_ack();
        do_eoi();
        cyc(1);
        chk("t5_reflag", {15'b0, flag}, 16'h1);
        irq = 8'h00;
        cyc(3);
        chk("t5_flag_held", {15'b0, flag}, 16'h1);
        cyc(1);
        chk("t5_withdrawn", {15'b0, flag}, 16'h0);

        // Asynchronous reset in service with two bits pending.
        wreg(2'd1, 16'h00FF);
        wreg(2'd0, 16'h00FF);
        pulse(8'h01);
        cyc(3);
        chk("t6_ch0", {8'h00, ch}, 16'h0);
        pulse(8'h0A);
        cyc(2);
        do_ack();
        rd("t6_status_svc", 2'd3, 16'h0200);
        rd("t6_pending", 2'd2, 16'h000A);
        cyc(1);
        rst = 1'b0;
        #1;
        chk("t6_rst_flag", {15'b0, flag}, 16'h0);
        rd("t6_rst_pending", 2'd2, 16'h0000);
        rd("t6_rst_mask", 2'd0, 16'h0000);
        cyc(2);
        rst = 1'b1;
        cyc(6);
        chk("t6_no_req", {15'b0, flag}, 16'h0);
        rd("t6_status_after", 2'd3, 16'h0000);

        cyc(1);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
